// File: rtl/control_sumador_serial_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the counter-width helper.
package control_sumador_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUMA = 2'd1,
      FIN  = 2'd2
   } estado_t;

   // Ceiling log2 with a floor of 1 so an N=1 counter still has one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/control_sumador_serial_fa.sv
// The team's 1-bit full-adder cell, shared by every bit of a serial addition.
module control_sumador_serial_fa (
   input  logic Bit1,
   input  logic Bit2,
   input  logic CarryIn,
   output logic Sum,
   output logic CarryOut
);

   assign Sum      = Bit1 ^ Bit2 ^ CarryIn;
   assign CarryOut = (Bit1 & Bit2) | (CarryIn & (Bit1 ^ Bit2));

endmodule

// File: rtl/control_sumador_serial.sv
// Bit-serial N-bit adder: one full-adder cell walked LSB-first over N cycles,
// with the registered sum and carry published alongside a one-cycle Done pulse.
module control_sumador_serial
   import control_sumador_serial_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         CarryIn,
   output logic         Ready,
   output logic         Done,
   output logic [N-1:0] Result,
   output logic         CarryOut,
   output logic [1:0]   estado
);

   localparam int            CW   = clog2_min1(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   estado_t       state, state_n;
   logic [N-1:0]  sha, shb, shs, shs_n;
   logic          carry;
   logic [CW-1:0] cnt;
   logic          fa_s, fa_co;
   logic          ultimo;

   control_sumador_serial_fa u_fa (
      .Bit1     (sha[0]),
      .Bit2     (shb[0]),
      .CarryIn  (carry),
      .Sum      (fa_s),
      .CarryOut (fa_co)
   );

   // Sum bits enter at the MSB so after N shifts bit 0 of the sum sits at bit 0.
   assign shs_n  = N'({fa_s, shs} >> 1);
   assign ultimo = (cnt == LAST);

   // Handshake: an operation is accepted on a rising edge where Start=1 and
   // Ready=1; Start while Ready=0 is dropped, never queued.
   assign Ready  = (state == IDLE);
   assign Done   = (state == FIN);
   assign estado = state;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (Start) state_n = SUMA;
         SUMA:    if (ultimo) state_n = FIN;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         sha      <= '0;
         shb      <= '0;
         shs      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         Result   <= '0;
         CarryOut <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (Start) begin
                  sha   <= A;
                  shb   <= B;
                  carry <= CarryIn;
                  cnt   <= '0;
                  shs   <= '0;
               end
            end
            SUMA: begin
               sha   <= sha >> 1;
               shb   <= shb >> 1;
               shs   <= shs_n;
               carry <= fa_co;
               cnt   <= cnt + CW'(1);
               // Outputs move only here, so they are never seen half-updated.
               if (ultimo) begin
                  Result   <= shs_n;
                  CarryOut <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sumador_serial.sv
// Self-checking bench for control_sumador_serial: vector table, scoreboard
// queue fed at acceptance and drained on Done, plus hand-written corner cases.
module tb_control_sumador_serial;

   localparam int N = 8;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset, start, cin;
   logic [N-1:0] a, b;
   logic         ready, done, cout;
   logic [N-1:0] result;
   logic [1:0]   estado;

   logic         start1, a1, b1, cin1;
   logic         ready1, done1, cout1, result1;
   logic [1:0]   estado1;

   control_sumador_serial #(.N(N)) dut (
      .Clk(clk), .Reset(reset), .Start(start), .A(a), .B(b), .CarryIn(cin),
      .Ready(ready), .Done(done), .Result(result), .CarryOut(cout), .estado(estado)
   );

   control_sumador_serial #(.N(1)) dut1 (
      .Clk(clk), .Reset(reset), .Start(start1), .A(a1), .B(b1), .CarryIn(cin1),
      .Ready(ready1), .Done(done1), .Result(result1), .CarryOut(cout1), .estado(estado1)
   );

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         cin;
      logic [N-1:0] r;
      logic         co;
   } vec_t;

   vec_t         tabla [6];
   logic [N:0]   exp_q [$];
   int           checks = 0;
   int           passed = 0;
   int           done_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every Done pops one expected {carry, sum}.
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) check("done_unexpected", {31'd0, done}, 32'd0);
         else check("sum", {23'd0, cout, result}, {23'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_done(input string name);
      int g;
      g = 0;
      while (!done && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (!done) check({name, "_timeout"}, {31'd0, done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc,
                         input logic [N:0] expv);
      int g;
      g = 0;
      while (!ready && g < 40) begin
         @(negedge clk);
         g++;
      end
      if (!ready) check("ready_timeout", {31'd0, ready}, 32'd1);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      exp_q.push_back(expv);
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
      wait_done("op");
   endtask

   initial begin
      int d0;
      logic [N-1:0] ra, rb;
      logic         rc;

      tabla[0] = '{a: 8'h3C, b: 8'h05, cin: 1'b0, r: 8'h41, co: 1'b0};
      tabla[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, r: 8'h00, co: 1'b1};
      tabla[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, r: 8'h00, co: 1'b1};
      tabla[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, r: 8'h00, co: 1'b0};
      tabla[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, r: 8'hFF, co: 1'b1};
      tabla[5] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, r: 8'h80, co: 1'b0};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready",  {31'd0, ready},  32'd1);
      check("rst_done",   {31'd0, done},   32'd0);
      check("rst_result", {24'd0, result}, 32'd0);
      check("rst_cout",   {31'd0, cout},   32'd0);
      check("rst_estado", {30'd0, estado}, 32'd0);
      check("rst1_ready", {31'd0, ready1}, 32'd1);

      // N=1: one SUMA cycle, Done two cycles after acceptance.
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      check("n1_done_early", {31'd0, done1}, 32'd0);
      @(negedge clk);
      check("n1_done",   {31'd0, done1},   32'd1);
      check("n1_result", {31'd0, result1}, 32'd1);
      check("n1_cout",   {31'd0, cout1},   32'd1);
      @(negedge clk);
      check("n1_ready",  {31'd0, ready1},  32'd1);

      // Exact latency: Done only in k+N+1, Ready back in k+N+2.
      a = 8'h3C; b = 8'h05; cin = 1'b0; start = 1'b1;
      exp_q.push_back(9'h041);
      for (int j = 1; j <= N + 2; j++) begin
         @(negedge clk);
         start = 1'b0;
         check("lat_done",  {31'd0, done},  {31'd0, (j == N + 1)});
         check("lat_ready", {31'd0, ready}, {31'd0, (j == N + 2)});
      end

      for (int i = 0; i < 6; i++)
         run_op(tabla[i].a, tabla[i].b, tabla[i].cin, {tabla[i].co, tabla[i].r});

      // Start re-pulsed during SUMA with other operands must be ignored.
      d0 = done_cnt;
      a = 8'h21; b = 8'h13; cin = 1'b0; start = 1'b1;
      exp_q.push_back(9'h034);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h11; b = 8'h22; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignore");
      repeat (12) @(negedge clk);
      check("ignore_one_done", done_cnt - d0, 32'd1);

      // Reset during SUMA aborts: no Done, outputs cleared.
      d0 = done_cnt;
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready",  {31'd0, ready},  32'd1);
      check("abort_result", {24'd0, result}, 32'd0);
      check("abort_cout",   {31'd0, cout},   32'd0);
      repeat (12) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 32'd0);

      // Held Start: back-to-back, Done every N+2 cycles.
      a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
      repeat (3) exp_q.push_back(9'h100);
      for (int j = 0; j <= 30; j++) begin
         if (j == 21) start = 1'b0;
         if (j > 0) check("held_done", {31'd0, done}, {31'd0, (j == 9 || j == 19 || j == 29)});
         @(negedge clk);
      end

      for (int i = 0; i < 1000; i++) begin
         ra = N'($urandom_range(0, 255));
         rb = N'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc});
      end

      repeat (4) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
